countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100, meaning clk cycles per counted second (range 2..2^16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port digit, input, 4 bits: keypad BCD digit.
REQ-005 The block SHALL have port digit_valid, input, 1 bit: one-cycle strobe qualifying digit.
REQ-006 The block SHALL have port limpaN, input, 1 bit: clear button, active-low, level.
REQ-007 The block SHALL have port run, input, 1 bit: magnetron-on latch state; counting is enabled only while high.
REQ-008 The block SHALL have port portafechada, input, 1 bit: door closed; counting pauses while low.
REQ-009 The block SHALL have ports min_tens, min_ones, sec_tens and sec_ones, each output, 4 bits: remaining time mm:ss in BCD.
REQ-010 The block SHALL have port tdone, output, 1 bit: level, high only in state DONE; it drives the controller's t_done.

Function
REQ-011 The FSM SHALL have states IDLE (time 00:00, stopped), SET (time nonzero, stopped), RUN and DONE.
REQ-012 Counting SHALL be enabled (cnt_en) when run=1 and portafechada=1.
REQ-013 In IDLE: digit entry with nonzero result -> SET; cnt_en with time 00:00 -> DONE on the next edge (start with no time ends immediately).
REQ-014 In SET: cnt_en -> RUN; a digit entry is accepted.
REQ-015 In RUN: cnt_en low -> SET (pause); the prescaler value is held.
REQ-016 In DONE: a digit entry -> SET; limpaN low -> IDLE; tdone stays high until one of these occurs.
REQ-017 Digit entry SHALL be accepted only in IDLE, SET or DONE with digit_valid=1 and digit<=9, and SHALL be ignored otherwise (including during RUN).
REQ-018 Digit entry SHALL shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit; the old min_tens is discarded.
REQ-019 In DONE, the first accepted digit SHALL start from 00:00 before the shift.
REQ-020 The prescaler SHALL count 0..TICK_DIV-1 in RUN while cnt_en is high.
REQ-021 The wrap from TICK_DIV-1 to 0 SHALL produce a one-second decrement in the same cycle.
REQ-022 The decrement SHALL be BCD with borrow: sec_ones 0->9 borrows sec_tens; sec_tens 0->5 borrows min_ones; min_ones 0->9 borrows min_tens.
REQ-023 Entered seconds 60..99 SHALL count down literally (e.g. 0:90, 0:89, ...).
REQ-024 A decrement reaching 00:00 SHALL move the FSM to DONE, with tdone high in the same cycle the display shows 00:00.
REQ-025 limpaN low SHALL, in any state, zero the digits and the prescaler and enter IDLE, and SHALL take priority over digit entry, ticks and cnt_en.
REQ-026 While limpaN is held low, the FSM SHALL stay in IDLE and SHALL NOT enter DONE even if cnt_en is high.
REQ-027 digit_valid coinciding with a tick SHALL be ignored, because entry is blocked in RUN.
REQ-028 The prescaler SHALL be cleared on any accepted digit entry and on clear.

Reset
REQ-029 rst high SHALL immediately force: state IDLE, all digits 0, prescaler 0, tdone 0.
REQ-030 Reset asserted mid-count SHALL discard the remaining time.
REQ-031 Operation SHALL resume on the first clk edge after rst deasserts.

Configuration
REQ-032 Macro COUNTDOWN_ADD30_EN, when defined, SHALL add input port add30 (1 bit, one-cycle strobe, "+30 s").
REQ-033 With the macro defined, add30 SHALL be honoured in every state, except that limpaN low overrides it.
REQ-034 The add30 arithmetic SHALL be: sec_tens+3; if the result is >=6, sec_tens-=6 and a minute is carried into min_ones/min_tens.
REQ-035 If the +30 carry would pass 99 minutes, the time SHALL saturate to 99:59.
REQ-036 add30 SHALL move IDLE or DONE (starting from 00:00) to SET, SHALL keep SET or RUN, and SHALL NOT disturb the prescaler.
REQ-037 add30 coinciding with a tick SHALL apply the decrement first, then +30.
REQ-038 Without the macro, the port and its logic SHALL be absent, and behaviour SHALL equal REQ-001..031.

Verification
REQ-039 Entry, TICK_DIV=4: digits 1,3,0 -> display 01:30, state SET, tdone 0; digit 12 -> ignored.
REQ-040 Borrow: 01:00, run=1, portafechada=1 -> after 4 clk display 00:59, after 240 clk 00:00 with tdone 1.
REQ-041 Pause: in RUN, portafechada=0 for 10 clk -> display frozen, state SET; on resume the next decrement arrives after the remaining prescaler count.
REQ-042 Zero start: IDLE, run=1 -> DONE next edge, tdone 1; digit 5 -> 00:05, SET, tdone 0.
REQ-043 Clear vs entry: limpaN=0 with digit_valid=1 at 00:45 in RUN -> 00:00, IDLE; asserting rst mid-run -> all outputs 0 asynchronously.
REQ-044 With COUNTDOWN_ADD30_EN: 00:45 +30 -> 01:15; 99:45 +30 -> 99:59; add30 in DONE -> 00:30, SET.

Source files
------------

// File: rtl/countdown_timer.sv
//------------------------------------------------------------------------------
// countdown_timer
//   Keypad-loaded mm:ss BCD countdown timer for the oven controller.
//   Digits shift in from the right, a prescaler of TICK_DIV clk cycles
//   produces one-second BCD decrements while counting is enabled, and
//   tdone is held high once the time runs out.
//   Optional feature: define COUNTDOWN_ADD30_EN to add the add30 "+30 s" input.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module countdown_timer #(
  parameter int TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       limpaN,
  input  logic       run,
  input  logic       portafechada,
`ifdef COUNTDOWN_ADD30_EN
  input  logic       add30,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       tdone
);

  localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SET  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state, w_state_nx;
  logic [15:0]          r_time, w_time_nx;   // {min_tens, min_ones, sec_tens, sec_ones}
  logic [15:0]          w_base;
  logic [15:0]          w_dec;
  logic [c_PRESC_W-1:0] r_presc, w_presc_nx;
  logic                 w_cnt_en;
  logic                 w_entry;
  logic                 w_tick;

  // One-second BCD decrement with borrow; never applied to 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

`ifdef COUNTDOWN_ADD30_EN
  // +30 s on the seconds-tens digit with minute carry, saturating at 99:59.
  function automatic logic [15:0] bcd_add30(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[7:4] >= 4'd3) begin
      r[7:4] = t[7:4] - 4'd3;
      if (t[11:8] != 4'd9) begin
        r[11:8] = t[11:8] + 4'd1;
      end else if (t[15:12] != 4'd9) begin
        r[11:8]  = 4'd0;
        r[15:12] = t[15:12] + 4'd1;
      end else begin
        r = 16'h9959;
      end
    end else begin
      r[7:4] = t[7:4] + 4'd3;
    end
    return r;
  endfunction
`endif

  assign w_cnt_en = run & portafechada;
  assign w_entry  = digit_valid && (digit <= 4'd9) && (r_state != S_RUN);
  assign w_tick   = (r_state == S_RUN) && w_cnt_en && (r_presc == c_PRESC_MAX);
  assign w_dec    = bcd_dec(r_time);

  // State, time and prescaler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_time  <= 16'h0000;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nx;
      r_time  <= w_time_nx;
      r_presc <= w_presc_nx;
    end
  end

  // Next-state, next-time and prescaler logic; clear overrides everything.
  always_comb begin
    w_state_nx = r_state;
    w_time_nx  = r_time;
    w_presc_nx = r_presc;
    w_base     = r_time;
    if (!limpaN) begin
      w_state_nx = S_IDLE;
      w_time_nx  = 16'h0000;
      w_presc_nx = '0;
    end else begin
      case (r_state)
        S_IDLE, S_SET, S_DONE: begin
          if (w_entry) begin
            // A fresh entry after completion starts from 00:00.
            w_base     = (r_state == S_DONE) ? 16'h0000 : r_time;
            w_time_nx  = {w_base[11:0], digit};
            w_presc_nx = '0;
            w_state_nx = (w_time_nx != 16'h0000) ? S_SET : S_IDLE;
          end else if (w_cnt_en) begin
            // Starting with no time loaded finishes at once.
            w_state_nx = (r_state == S_SET) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (!w_cnt_en) begin
            w_state_nx = S_SET;
          end else if (w_tick) begin
            w_presc_nx = '0;
            w_time_nx  = w_dec;
            w_state_nx = (w_dec == 16'h0000) ? S_DONE : S_RUN;
          end else begin
            w_presc_nx = r_presc + 1'b1;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
`ifdef COUNTDOWN_ADD30_EN
      // +30 s lands after any same-cycle decrement or entry.
      if (add30) begin
        w_time_nx = bcd_add30(w_time_nx);
        if ((w_state_nx == S_IDLE) || (w_state_nx == S_DONE)) begin
          w_state_nx = (r_state == S_RUN) ? S_RUN : S_SET;
        end
      end
`endif
    end
  end

  assign min_tens = r_time[15:12];
  assign min_ones = r_time[11:8];
  assign sec_tens = r_time[7:4];
  assign sec_ones = r_time[3:0];
  assign tdone    = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
//------------------------------------------------------------------------------
// tb_countdown_timer
//   Directed and random stimulus against a seconds-level reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_countdown_timer;

  localparam int TICK_DIV = 4;
  localparam int P_IDLE = 0;
  localparam int P_SET  = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit;
  logic       digit_valid;
  logic       limpaN;
  logic       run;
  logic       portafechada;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       tdone;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining time as minutes/seconds integers.
  int m_mm, m_ss, m_pre, m_phase;

  countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .digit       (digit),
    .digit_valid (digit_valid),
    .limpaN      (limpaN),
    .run         (run),
    .portafechada(portafechada),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .tdone       (tdone)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] observed();
    return {min_tens, min_ones, sec_tens, sec_ones, tdone};
  endfunction

  function automatic logic [16:0] expected();
    logic [16:0] e;
    e[16:13] = 4'(m_mm / 10);
    e[12:9]  = 4'(m_mm % 10);
    e[8:5]   = 4'(m_ss / 10);
    e[4:1]   = 4'(m_ss % 10);
    e[0]     = (m_phase == P_DONE);
    return e;
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mm = 0; m_ss = 0; m_pre = 0; m_phase = P_IDLE;
  endtask

  task automatic model_step(input bit lim, input bit dv, input int d, input bit rn, input bit pf);
    bit en;
    bit entry;
    int v;
    en    = rn && pf;
    entry = dv && (d <= 9) && (m_phase != P_RUN);
    if (!lim) begin
      model_reset();
    end else if (entry) begin
      v = (m_phase == P_DONE) ? 0 : m_mm * 100 + m_ss;
      v = (v % 1000) * 10 + d;
      m_mm = v / 100;
      m_ss = v % 100;
      m_pre = 0;
      m_phase = (v != 0) ? P_SET : P_IDLE;
    end else if (m_phase == P_RUN) begin
      if (!en) begin
        m_phase = P_SET;
      end else if (m_pre == TICK_DIV - 1) begin
        m_pre = 0;
        if (m_ss > 0) m_ss--;
        else begin m_ss = 59; m_mm--; end
        if (m_mm == 0 && m_ss == 0) m_phase = P_DONE;
      end else begin
        m_pre++;
      end
    end else if (en) begin
      if (m_phase == P_SET) m_phase = P_RUN;
      else if (m_phase == P_IDLE) m_phase = P_DONE;
    end
  endtask

  // One clock with the given inputs, then compare DUT against model.
  task automatic cyc(input string tag, input bit lim, input bit dv, input int d,
                     input bit rn, input bit pf);
    limpaN = lim; digit_valid = dv; digit = 4'(d); run = rn; portafechada = pf;
    @(posedge clk);
    model_step(lim, dv, d, rn, pf);
    @(negedge clk);
    check(tag, observed(), expected());
  endtask

  initial begin
    rst = 1'b1; limpaN = 1'b1; digit_valid = 1'b0; digit = 4'd0;
    run = 1'b0; portafechada = 1'b1;
    model_reset();
    #3;
    check("reset", observed(), 17'h0);
    @(negedge clk);
    rst = 1'b0;

    // Entry 1,3,0 then an invalid digit 12.
    cyc("entry1", 1, 1, 1, 0, 1);
    cyc("entry3", 1, 1, 3, 0, 1);
    cyc("entry0", 1, 1, 0, 0, 1);
    check("entry_0130", observed(), {16'h0130, 1'b0});
    cyc("digit12", 1, 1, 12, 0, 1);
    check("digit12_ignored", observed(), {16'h0130, 1'b0});

    // Borrow across a minute and run to completion.
    cyc("clr", 0, 0, 0, 0, 1);
    cyc("e1", 1, 1, 1, 0, 1);
    cyc("e0a", 1, 1, 0, 0, 1);
    cyc("e0b", 1, 1, 0, 0, 1);
    cyc("start", 1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc("borrow", 1, 0, 0, 1, 1);
    check("borrow_0059", observed(), {16'h0059, 1'b0});
    for (int i = 0; i < 236; i++) cyc("count", 1, 0, 0, 1, 1);
    check("done_0000", observed(), {16'h0000, 1'b1});
    cyc("done_hold", 1, 0, 0, 0, 1);

    // Pause mid-second with the door open, then resume.
    cyc("p_e1", 1, 1, 1, 0, 1);
    cyc("p_e0", 1, 1, 0, 0, 1);
    cyc("p_start", 1, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc("p_run", 1, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) cyc("p_door", 1, 0, 0, 1, 0);
    check("pause_frozen", observed(), {16'h0009, 1'b0});
    for (int i = 0; i < 6; i++) cyc("p_resume", 1, 0, 0, 1, 1);

    // Zero start finishes at once; a digit restarts entry.
    cyc("z_clr", 0, 0, 0, 0, 1);
    cyc("z_run", 1, 0, 0, 1, 1);
    check("zero_start_done", observed(), {16'h0000, 1'b1});
    cyc("z_dig", 1, 1, 5, 0, 1);
    check("done_digit5", observed(), {16'h0005, 1'b0});

    // Clear beats entry while running.
    cyc("c_clr", 0, 0, 0, 0, 1);
    cyc("c_e4", 1, 1, 4, 0, 1);
    cyc("c_e5", 1, 1, 5, 0, 1);
    for (int i = 0; i < 3; i++) cyc("c_run", 1, 0, 0, 1, 1);
    cyc("c_clr_dv", 0, 1, 7, 1, 1);
    check("clear_vs_entry", observed(), {16'h0000, 1'b0});
    cyc("c_hold_clr", 0, 0, 0, 1, 1);
    check("clear_blocks_done", observed(), {16'h0000, 1'b0});

    // Asynchronous reset mid-run.
    cyc("r_e3", 1, 1, 3, 0, 1);
    cyc("r_e7", 1, 1, 7, 0, 1);
    for (int i = 0; i < 6; i++) cyc("r_run", 1, 0, 0, 1, 1);
    rst = 1'b1;
    #1;
    check("async_reset", observed(), 17'h0);
    model_reset();
    @(negedge clk);
    check("reset_held", observed(), 17'h0);
    rst = 1'b0;
    cyc("after_reset", 1, 1, 2, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc("random",
          $urandom_range(0, 99) >= 2,
          $urandom_range(0, 5) == 0,
          int'($urandom_range(0, 15)),
          $urandom_range(0, 9) != 0,
          $urandom_range(0, 9) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
